// File: rtl/mult_seq_arbiter.sv
// mult_seq_arbiter
//   Two-requester round-robin front end to a sequential 8x8 unsigned multiplier
//   built from one shared 2x2-bit multiplier stepped over 16 digit pairs.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req0_valid/a/b/ready  requester 0 handshake and 8-bit operands
//   req1_valid/a/b/ready  requester 1 handshake and 8-bit operands
//   res_valid/id/product  result handshake, owning requester and 16-bit product
//   res_ready             consumer accepts the result
//   busy                  high whenever the block is not idle
//
// Configuration
//   MULT_SEQ_ZERO_SKIP_EN  when defined, a zero operand finishes after one CALC
//                          edge with a zero product instead of all 16 steps.
module mult_seq_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ready,
    output logic        res_valid,
    output logic        res_id,
    output logic [15:0] res_product,
    input  logic        res_ready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic        id_reg;
    logic [15:0] acc;
    logic [3:0]  step;
    logic        last;      // requester served most recently

    // Round-robin grant: on a tie the requester not served last wins.
    logic grant_any;
    logic grant_id;

    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_id  = ~last;
        end else if (req0_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b0;
        end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
        end
    end

    // Ready is gated by rst so it is low for the whole reset pulse.
    assign req0_ready = !rst && (state == IDLE) && grant_any && !grant_id;
    assign req1_ready = !rst && (state == IDLE) && grant_any &&  grant_id;
    assign busy       = (state != IDLE);

    // Shared 2x2 multiplier: step selects digit p of a and digit q of b.
    logic [1:0]  dig_p;
    logic [1:0]  dig_q;
    logic [1:0]  a_dig;
    logic [1:0]  b_dig;
    logic [3:0]  prod4;
    logic [2:0]  pq_sum;
    logic [3:0]  shamt;
    logic [15:0] partial;
    logic [15:0] acc_next;
    logic        skip;

    assign dig_p    = step[3:2];
    assign dig_q    = step[1:0];
    assign a_dig    = a_reg[{dig_p, 1'b0} +: 2];
    assign b_dig    = b_reg[{dig_q, 1'b0} +: 2];
    assign prod4    = {2'b00, a_dig} * {2'b00, b_dig};
    assign pq_sum   = {1'b0, dig_p} + {1'b0, dig_q};
    assign shamt    = {pq_sum, 1'b0};
    assign partial  = {12'd0, prod4} << shamt;
    assign acc_next = acc + partial;

`ifdef MULT_SEQ_ZERO_SKIP_EN
    assign skip = (a_reg == 8'd0) || (b_reg == 8'd0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_reg       <= 8'd0;
            b_reg       <= 8'd0;
            id_reg      <= 1'b0;
            acc         <= 16'd0;
            step        <= 4'd0;
            last        <= 1'b1;
            res_valid   <= 1'b0;
            res_id      <= 1'b0;
            res_product <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        a_reg  <= grant_id ? req1_a : req0_a;
                        b_reg  <= grant_id ? req1_b : req0_b;
                        id_reg <= grant_id;
                        last   <= grant_id;
                        acc    <= 16'd0;
                        step   <= 4'd0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc  <= acc_next;
                    step <= step + 4'd1;
                    if (skip || (step == 4'd15)) begin
                        state       <= DONE;
                        res_valid   <= 1'b1;
                        res_id      <= id_reg;
                        res_product <= skip ? 16'd0 : acc_next;
                    end
                end
                DONE: begin
                    // No grant on this edge: ready is only driven in IDLE.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mult_seq_arbiter.md
MULT_SEQ_ARBITER -- requirements
Module: mult_seq_arbiter

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning); one clock, and reset is asynchronous and active-high:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous active-high reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a, req0_b  in  8 each  requester 0 operands, unsigned.
- req0_ready  out  1  requester 0 pair accepted this cycle.
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_id  out  1  requester that owns the result.
- res_product  out  16  unsigned product.
- res_ready  in  1  consumer takes the result.
- busy  out  1  high when state is not IDLE.
REQ-002 The block SHALL have no parameters; widths are fixed.

Function
REQ-003 The FSM SHALL have states IDLE, CALC and DONE.
REQ-004 In IDLE, reqN_ready SHALL be driven combinationally high only for the granted requester.
- Only one requester is granted at a time.
- Grant requires the requester's valid to be high.
- Outside IDLE, both ready outputs SHALL be 0.
REQ-005 Arbitration SHALL be round-robin:
- One valid requester: grant it.
- Both valid: grant the requester that was not served last.
- The last-served pointer SHALL update on accept.
REQ-006 Accept SHALL occur on the edge where valid and ready are both high (edge E0). On that edge the block SHALL:
- capture a, b and the requester id;
- clear the accumulator and step counter;
- enter CALC.
REQ-007 The datapath SHALL be one shared 2x2-bit unsigned multiplier producing a 4-bit product. Its truth table SHALL be exact, including 3x3 = 9.
REQ-008 CALC SHALL take 16 edges, E1..E16. At step i (0..15):
- digit index p = i[3:2], digit index q = i[1:0];
- acc += (a[2p+1:2p] * b[2q+1:2q]) << 2(p+q), in 16-bit arithmetic;
- the sum never overflows 16 bits.
REQ-009 On E16 the block SHALL enter DONE and set res_valid=1, with res_product=acc and res_id equal to the captured id. Latency from accept is 16 cycles.
REQ-010 In DONE, res_valid, res_product and res_id SHALL hold stable until res_ready is high. On that edge the block SHALL:
- clear res_valid;
- return to IDLE;
- grant no requester on the same edge.
REQ-011 res_ready in IDLE or CALC SHALL have no effect.
REQ-012 Requester behaviour outside accept:
- Dropping valid before accept SHALL be legal and SHALL capture nothing.
- Operand changes after E0 SHALL be ignored.
REQ-013 busy SHALL be 1 in CALC and DONE and 0 in IDLE.

Reset
REQ-014 Asserting rst SHALL immediately force:
- state IDLE;
- res_valid=0, res_product=0, res_id=0;
- accumulator and step counter cleared;
- last-served pointer = 1, so requester 0 wins the first tie.
REQ-015 Reset during CALC or DONE SHALL discard the transaction; no result is produced. After rst deasserts, the next accept SHALL compute correctly.
REQ-016 While rst is high, req0_ready, req1_ready and busy SHALL be 0.

Configuration
REQ-017 Macro MULT_SEQ_ZERO_SKIP_EN SHALL control zero-skip.
- Defined: if the captured a==0 or b==0, the block SHALL go from CALC to DONE on E1 with res_product=0. Latency is 1 cycle.
- Undefined: all operands take the full 16 steps.
- The result value is identical either way.

Verification
REQ-018 Single product: req0 a=0xFF, b=0xFF, res_ready=1 -> res_valid rises at E16 with res_product=0xFE01, res_id=0; busy returns to 0 one edge later.
REQ-019 Tie after reset: req0 (0x03, 0x03) and req1 (0x12, 0x34) both valid ->
- first result res_id=0, product 0x0009;
- second result res_id=1, product 0x03A8;
- req1_ready stays 0 until the block is back in IDLE.
REQ-020 Fairness: both valid continuously for 4 transactions -> res_id sequence 0,1,0,1.
REQ-021 Backpressure: res_ready held low 5 cycles in DONE -> res_valid, res_product and res_id stay constant; no readys assert; accept resumes after the res_ready edge.
REQ-022 Reset: rst pulsed at CALC step 8 -> all outputs 0 and state IDLE immediately. A following req1 (0x0A, 0x0B) yields 0x006E.
REQ-023 Zero operand: req0 a=0x00, b=0x55 -> res_product=0x0000.
- res_valid at E1 with MULT_SEQ_ZERO_SKIP_EN defined.
- res_valid at E16 without it.
